// File: rtl/lsu_mem_bridge_if.sv
// lsu_mem_bridge_if: req/gnt/rvalid memory port between the load/store unit and memory
interface lsu_mem_bridge_if #(parameter int XLEN = 64) ();
  logic                mem_req_o;
  logic                mem_we_o;
  logic [XLEN-1:0]     mem_addr_o;
  logic [XLEN-1:0]     mem_wdata_o;
  logic [XLEN/8-1:0]   mem_wmask_o;
  logic                mem_gnt_i;
  logic                mem_rvalid_i;
  logic [XLEN-1:0]     mem_rdata_i;
  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge: MEM-stage load/store unit with in-order store buffer and blocking loads
module lsu_mem_bridge #(
  parameter int XLEN     = 64,
  parameter int SB_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ren_i,
  input  logic                wen_i,
  input  logic [XLEN-1:0]     addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [XLEN/8-1:0]   wmask_i,
  input  logic [2:0]          funct3_i,
  input  logic                flush_i,
  output logic                stall_flag_o,
  output logic [XLEN-1:0]     rdata_o,
  output logic                rdata_valid_o,
  output logic                sb_empty_o,
  lsu_mem_bridge_if.master    mem
);
  localparam int BYTES = XLEN / 8;
  localparam int OFS_W = $clog2(BYTES);
  localparam int PTR_W = $clog2(SB_DEPTH);
  typedef enum logic [2:0] {IDLE, LD_REQ, LD_WAIT, LD_DONE, LD_DROP} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0]  sb_addr [SB_DEPTH];
  logic [XLEN-1:0]  sb_data [SB_DEPTH];
  logic [BYTES-1:0] sb_mask [SB_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic [XLEN-1:0]  ld_addr, word_addr, sh, ext;
  logic [2:0]       ld_f3;
  logic             drain_busy, hazard, full, empty, ld_go, drain, push, pop, ld_stall;
  assign word_addr = {addr_i[XLEN-1:OFS_W], {OFS_W{1'b0}}};
  assign full      = count == (PTR_W+1)'(SB_DEPTH);
  assign empty     = count == '0;
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++)
      if (({1'b0, PTR_W'(i) - head} < count) && sb_addr[i] == word_addr) hazard = 1'b1;
  end
  // a drain request already on the bus keeps priority so its fields stay stable until gnt
  assign ld_go    = state == IDLE && ren_i && !hazard && !drain_busy;
  assign drain    = state == IDLE && !empty && !ld_go;
  assign push     = wen_i && !full;
  assign pop      = drain && mem.mem_gnt_i;
  assign ld_stall = ((state == IDLE || state == LD_DROP) && ren_i) || state == LD_REQ || state == LD_WAIT;
  assign stall_flag_o  = ld_stall || (wen_i && full);
  assign rdata_valid_o = state == LD_DONE;
  assign sb_empty_o    = empty;
  assign mem.mem_req_o   = drain || state == LD_REQ;
  assign mem.mem_we_o    = drain;
  assign mem.mem_addr_o  = drain ? sb_addr[head] : state == LD_REQ ? {ld_addr[XLEN-1:OFS_W], {OFS_W{1'b0}}} : '0;
  assign mem.mem_wdata_o = drain ? sb_data[head] : '0;
  assign mem.mem_wmask_o = drain ? sb_mask[head] : '0;
  assign sh  = mem.mem_rdata_i >> {ld_addr[OFS_W-1:0], 3'b000};
  assign ext = ld_f3[1:0] == 2'd0 ? (ld_f3[2] ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]))) :
               ld_f3[1:0] == 2'd1 ? (ld_f3[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]))) :
               ld_f3[1:0] == 2'd2 ? (ld_f3[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]))) : sh;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = ld_go ? LD_REQ : IDLE;
      LD_REQ:  state_nx = mem.mem_gnt_i ? (flush_i ? LD_DROP : LD_WAIT) : (flush_i ? IDLE : LD_REQ);
      LD_WAIT: state_nx = flush_i ? (mem.mem_rvalid_i ? IDLE : LD_DROP) : (mem.mem_rvalid_i ? LD_DONE : LD_WAIT);
      LD_DONE: state_nx = IDLE;
      LD_DROP: state_nx = mem.mem_rvalid_i ? IDLE : LD_DROP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      drain_busy <= 1'b0;
      ld_addr    <= '0;
      ld_f3      <= '0;
      rdata_o    <= '0;
    end else begin
      state      <= state_nx;
      head       <= pop ? head + 1'b1 : head;
      tail       <= push ? tail + 1'b1 : tail;
      count      <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      drain_busy <= drain && !mem.mem_gnt_i;
      if (ld_go) begin
        ld_addr <= addr_i;
        ld_f3   <= funct3_i;
      end
      if (state == LD_WAIT && mem.mem_rvalid_i && !flush_i) rdata_o <= ext;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[tail] <= word_addr;
      sb_data[tail] <= wdata_i;
      sb_mask[tail] <= wmask_i;
    end
  end
endmodule
